// File: rtl/word_serializer.sv
// word_serializer
//   Takes one parallel word through a load/ready handshake and sends it out on
//   one serial line. Each frame is a start bit (0), WIDTH data bits sent LSB
//   first, and a stop bit (1). Every serial bit is held for BIT_CYCLES clocks.
//
// Parameters
//   WIDTH       number of data bits in each frame (>= 1)
//   BIT_CYCLES  number of clk cycles that each serial bit stays on tx (>= 1)
//
// Ports
//   clk    in   1      system clock; all state changes on the rising edge
//   reset  in   1      synchronous, active-high reset; overrides every input
//   load   in   1      asks to send D; accepted only while ready=1
//   D      in   WIDTH  parallel word, captured on the edge that accepts it
//   ready  out  1      1 when idle, so a load in this cycle is accepted
//   busy   out  1      1 while a frame is being sent; always equal to ~ready
//   tx     out  1      registered serial line; sits at 1 when idle
//   done   out  1      high for exactly one cycle, the first idle cycle after a frame
module word_serializer #(
  parameter int WIDTH      = 5,
  parameter int BIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  output logic             ready,
  output logic             busy,
  output logic             tx,
  output logic             done
);

  // Both counters are at least one bit wide. This keeps the design legal
  // when BIT_CYCLES=1 or WIDTH=1.
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = ($clog2(WIDTH + 1) > 1) ? $clog2(WIDTH + 1) : 1;

  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cyc;
  logic [BW-1:0]    bitcnt;
  logic             tx_reg;
  logic             done_reg;
  logic             ready_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      cyc       <= '0;
      bitcnt    <= '0;
      tx_reg    <= 1'b1;
      done_reg  <= 1'b0;
      ready_reg <= 1'b1;
    end else begin
      // done defaults to 0 here. It is set only by the final edge of STOP,
      // so it is high only in the first idle cycle after a frame.
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          tx_reg <= 1'b1;
          if (load && ready_reg) begin
            shreg     <= D;
            tx_reg    <= 1'b0;
            bitcnt    <= '0;
            cyc       <= '0;
            ready_reg <= 1'b0;
            state     <= START;
          end
        end

        START: begin
          if (cyc == CYC_LAST) begin
            // Put bit 0 on the line now and shift, so shreg[0] is always
            // the next bit to send.
            tx_reg <= shreg[0];
            shreg  <= shreg >> 1;
            cyc    <= '0;
            bitcnt <= '0;
            state  <= DATA;
          end else begin
            cyc <= cyc + CW'(1);
          end
        end

        DATA: begin
          if (cyc == CYC_LAST) begin
            cyc <= '0;
            if (bitcnt == BIT_LAST) begin
              tx_reg <= 1'b1;
              state  <= STOP;
            end else begin
              tx_reg <= shreg[0];
              shreg  <= shreg >> 1;
              bitcnt <= bitcnt + BW'(1);
            end
          end else begin
            cyc <= cyc + CW'(1);
          end
        end

        STOP: begin
          if (cyc == CYC_LAST) begin
            cyc       <= '0;
            done_reg  <= 1'b1;
            ready_reg <= 1'b1;
            state     <= IDLE;
          end else begin
            cyc <= cyc + CW'(1);
          end
        end

        default: begin
          state     <= IDLE;
          tx_reg    <= 1'b1;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign tx    = tx_reg;
  assign done  = done_reg;
  assign ready = ready_reg;
  assign busy  = ~ready_reg;

endmodule

// File: tb/tb_word_serializer.sv
// Directed testbench for word_serializer. It uses two instances:
//   u_dut  : default parameters (WIDTH=5, BIT_CYCLES=4)
//   u_dut8 : WIDTH=8, BIT_CYCLES=1
// Every expected tx sequence is a hand-written constant. Bit i of each
// constant is the serial bit number i of the frame: start, the data bits
// LSB first, then stop.
module tb_word_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [4:0] d;
  logic       ready, busy, tx, done;

  logic       load8;
  logic [7:0] d8;
  logic       ready8, busy8, tx8, done8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  word_serializer #(.WIDTH(5), .BIT_CYCLES(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .D     (d),
    .ready (ready),
    .busy  (busy),
    .tx    (tx),
    .done  (done)
  );

  word_serializer #(.WIDTH(8), .BIT_CYCLES(1)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .load  (load8),
    .D     (d8),
    .ready (ready8),
    .busy  (busy8),
    .tx    (tx8),
    .done  (done8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge, then wait 1 time unit so the outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The accepting edge must have just happened (n=0). This task checks every
  // cycle of the frame and then the done cycle. It returns while the done
  // cycle is still current.
  // sel8=1 checks u_dut8. disturb=1 pulses load with D=5'b11111 so that
  // u_dut sees the pulse on edges E0+5 and E0+20.
  task automatic frame_chk(input string tag, input logic [15:0] seq, input int nbits,
                           input int bc, input bit sel8, input bit disturb);
    int flen;
    flen = nbits * bc;
    for (int n = 0; n < flen; n++) begin
      check($sformatf("%s tx n=%0d", tag, n), {31'd0, sel8 ? tx8 : tx}, {31'd0, seq[n / bc]});
      check($sformatf("%s busy n=%0d", tag, n), {31'd0, sel8 ? busy8 : busy}, 32'd1);
      check($sformatf("%s done n=%0d", tag, n), {31'd0, sel8 ? done8 : done}, 32'd0);
      if (disturb) begin
        if (n == 4 || n == 19) begin
          load = 1'b1;
          d    = 5'b11111;
        end else begin
          load = 1'b0;
        end
      end
      tick();
    end
    check({tag, " done"},  {31'd0, sel8 ? done8 : done},   32'd1);
    check({tag, " ready"}, {31'd0, sel8 ? ready8 : ready}, 32'd1);
    check({tag, " busy0"}, {31'd0, sel8 ? busy8 : busy},   32'd0);
    check({tag, " txidle"}, {31'd0, sel8 ? tx8 : tx},      32'd1);
    $display("frame %s: %0d cycles checked, bad so far=%0d", tag, flen, bad);
  endtask

  initial begin
    reset = 1'b1;
    load  = 1'b1;
    d     = 5'b10110;
    load8 = 1'b1;
    d8    = 8'hA5;

    // Test 1: hold reset with load=1. The line must stay idle.
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst tx %0d", i),    {31'd0, tx},    32'd1);
      check($sformatf("rst ready %0d", i), {31'd0, ready}, 32'd1);
      check($sformatf("rst busy %0d", i),  {31'd0, busy},  32'd0);
      check($sformatf("rst done %0d", i),  {31'd0, done},  32'd0);
      check($sformatf("rst tx8 %0d", i),   {31'd0, tx8},   32'd1);
    end
    load  = 1'b0;
    load8 = 1'b0;
    reset = 1'b0;
    tick();
    check("idle tx", {31'd0, tx}, 32'd1);
    $display("reset hold: checked");

    // Test 2: a single frame for 5'b10110 -> tx bits 0,0,1,1,0,1,1.
    load = 1'b1;
    d    = 5'b10110;
    tick();
    load = 1'b0;
    frame_chk("f10110", 16'b1101100, 7, 4, 1'b0, 1'b0);
    tick();
    check("f10110 done1cyc", {31'd0, done}, 32'd0);
    check("f10110 ready",    {31'd0, ready}, 32'd1);

    // Test 3: load pulses during the frame are ignored.
    load = 1'b1;
    d    = 5'b10110;
    tick();
    load = 1'b0;
    frame_chk("fdist", 16'b1101100, 7, 4, 1'b0, 1'b1);
    load = 1'b0;
    tick();
    check("fdist noretrig", {31'd0, busy}, 32'd0);

    // Test 4: load held high. Two frames go out back to back, and the
    // second one is accepted in the done cycle.
    load = 1'b1;
    d    = 5'b00001;
    tick();
    d = 5'b11110;
    frame_chk("fb2b1", 16'b1000010, 7, 4, 1'b0, 1'b0);
    tick();
    load = 1'b0;
    check("fb2b accept", {31'd0, tx}, 32'd0);
    frame_chk("fb2b2", 16'b1111100, 7, 4, 1'b0, 1'b0);
    tick();

    // Test 5: reset asserted at cycle 10 of a frame aborts it.
    load = 1'b1;
    d    = 5'b11111;
    tick();
    load = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort tx",    {31'd0, tx},    32'd1);
    check("abort ready", {31'd0, ready}, 32'd1);
    check("abort busy",  {31'd0, busy},  32'd0);
    for (int i = 0; i < 30; i++) begin
      tick();
      check($sformatf("abort nodone %0d", i), {31'd0, done}, 32'd0);
      check($sformatf("abort idle %0d", i),   {31'd0, tx},   32'd1);
    end
    $display("abort mid-frame: checked");
    load = 1'b1;
    d    = 5'b01101;
    tick();
    load = 1'b0;
    frame_chk("fpost", 16'b1011010, 7, 4, 1'b0, 1'b0);
    tick();

    // Test 6: WIDTH=8, BIT_CYCLES=1, D=8'hA5 -> 0,1,0,1,0,0,1,0,1,1.
    load8 = 1'b1;
    d8    = 8'hA5;
    tick();
    load8 = 1'b0;
    frame_chk("fA5", 16'b1101001010, 10, 1, 1'b1, 1'b0);
    tick();
    check("fA5 done1cyc", {31'd0, done8}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
